usb_bus_responder: RTL and testbench

//   FPGA-side responder for the SAM3U external parallel bus (addr/data/RDn/WRn/CEn), all sync to clk_usb.

---
 rtl/usb_bus_responder.sv | 236 +++++++++++++++++++++++
 tb/tb_usb_bus_responder.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_bus_responder.sv
// usb_bus_responder: turns SAM3U parallel-bus cycles (CEn/RDn/WRn) into
// single-cycle register strobes with a latched address and a burst byte
// index, and returns register read data after a fixed fetch latency.
// Optional feature macro: USB_BUS_TIMEOUT_EN enables an idle-CEn timeout
// that raises a sticky bus_error; without it bus_error is tied low.
module usb_bus_responder #(
    parameter int pADDR_WIDTH   = 8,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pREAD_LATENCY = 2,
    parameter int pTIMEOUT      = 255
) (
    input  logic                     clk_usb,
    input  logic                     reset_n,
    input  logic [pADDR_WIDTH-1:0]   usb_addr,
    input  logic [7:0]               usb_din,
    output logic [7:0]               usb_dout,
    output logic                     usb_isout,
    input  logic                     usb_rdn,
    input  logic                     usb_wrn,
    input  logic                     usb_cen,
    output logic [pADDR_WIDTH-1:0]   reg_address,
    output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    output logic [7:0]               reg_datao,
    input  logic [7:0]               reg_datai,
    output logic                     reg_read,
    output logic                     reg_write,
    output logic                     reg_addrvalid,
    output logic                     bus_error
);

    if (pREAD_LATENCY < 1 || pREAD_LATENCY > 7) begin : g_bad_latency
        $error("pREAD_LATENCY must be in 1..7");
    end
    if (pTIMEOUT < 1) begin : g_bad_timeout
        $error("pTIMEOUT must be at least 1");
    end

    localparam logic [2:0] READ_LAT = 3'(pREAD_LATENCY);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        READ_HOLD = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [pADDR_WIDTH-1:0] addr_r;
    logic [7:0]             din_r;
    logic                   rdn_r, wrn_r, cen_r;
    logic                   rdn_rr, wrn_rr;
    logic                   rdn_fall, wrn_fall;
    logic [2:0]             lat_cnt;

    logic start_write, start_read, finish_write, load_dout, read_done;
    logic timeout_hit;

    assign rdn_fall = rdn_rr & ~rdn_r;
    assign wrn_fall = wrn_rr & ~wrn_r;

    // Input stage: register pads once, strobes twice for edge detection
    always_ff @(posedge clk_usb) begin
        if (!reset_n) begin
            addr_r <= '0;
            din_r  <= '0;
            rdn_r  <= 1'b1;
            wrn_r  <= 1'b1;
            cen_r  <= 1'b1;
            rdn_rr <= 1'b1;
            wrn_rr <= 1'b1;
        end else begin
            addr_r <= usb_addr;
            din_r  <= usb_din;
            rdn_r  <= usb_rdn;
            wrn_r  <= usb_wrn;
            cen_r  <= usb_cen;
            rdn_rr <= rdn_r;
            wrn_rr <= wrn_r;
        end
    end

`ifdef USB_BUS_TIMEOUT_EN
    localparam int TMO_W = $clog2(pTIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             strobe_edge;

    assign strobe_edge = (rdn_r ^ rdn_rr) | (wrn_r ^ wrn_rr);
    assign timeout_hit = ~cen_r & (state_q == IDLE) & ~strobe_edge
                       & (tmo_cnt == TMO_W'(pTIMEOUT - 1));

    // Idle counter: runs while selected and idle, saturates so the error fires once
    always_ff @(posedge clk_usb) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (cen_r || state_q != IDLE || strobe_edge) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_W'(pTIMEOUT)) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Sticky error flag, released only by reset or chip-enable deassertion
    always_ff @(posedge clk_usb) begin
        if (!reset_n) begin
            bus_error <= 1'b0;
        end else if (cen_r) begin
            bus_error <= 1'b0;
        end else if (timeout_hit) begin
            bus_error <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign bus_error   = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk_usb) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and per-cycle action decodes
    always_comb begin
        state_d      = state_q;
        start_write  = 1'b0;
        start_read   = 1'b0;
        finish_write = 1'b0;
        load_dout    = 1'b0;
        read_done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!cen_r) begin
                    // write has priority when both strobes fall together
                    if (wrn_fall) begin
                        state_d     = WRITE;
                        start_write = 1'b1;
                    end else if (rdn_fall && wrn_r) begin
                        state_d    = READ_WAIT;
                        start_read = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (cen_r) begin
                    state_d = IDLE;
                end else if (wrn_r) begin
                    state_d      = IDLE;
                    finish_write = 1'b1;
                end
            end
            READ_WAIT: begin
                if (cen_r) begin
                    state_d = IDLE;
                end else if (lat_cnt == READ_LAT) begin
                    state_d   = READ_HOLD;
                    load_dout = 1'b1;
                end
            end
            READ_HOLD: begin
                // level test also covers an RDn released before the data load
                if (cen_r) begin
                    state_d = IDLE;
                end else if (rdn_r) begin
                    state_d   = IDLE;
                    read_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeout_hit) begin
            state_d = IDLE;
        end
    end

    // Read fetch latency counter; zero on the reg_read cycle
    always_ff @(posedge clk_usb) begin
        if (!reset_n) begin
            lat_cnt <= '0;
        end else if (state_q == READ_WAIT) begin
            lat_cnt <= lat_cnt + 3'd1;
        end else begin
            lat_cnt <= '0;
        end
    end

    // Register-side outputs, pad data and burst index bookkeeping
    always_ff @(posedge clk_usb) begin
        if (!reset_n) begin
            usb_dout      <= '0;
            usb_isout     <= 1'b0;
            reg_address   <= '0;
            reg_bytecnt   <= '0;
            reg_datao     <= '0;
            reg_read      <= 1'b0;
            reg_write     <= 1'b0;
            reg_addrvalid <= 1'b0;
        end else begin
            reg_read  <= start_read;
            reg_write <= finish_write;
            usb_isout <= ~cen_r & ~rdn_r & wrn_r;
            if (finish_write) begin
                reg_datao   <= din_r;
                reg_address <= addr_r;
            end
            if (load_dout) begin
                usb_dout <= reg_datai;
            end
            if (cen_r) begin
                reg_bytecnt   <= '0;
                reg_addrvalid <= 1'b0;
            end else begin
                // increment after the strobe so the index is stable while it is high
                if (reg_write || read_done) begin
                    reg_bytecnt <= reg_bytecnt + pBYTECNT_SIZE'(1);
                end
                if (start_write || start_read) begin
                    reg_address   <= addr_r;
                    reg_addrvalid <= 1'b1;
                    if (addr_r != reg_address) begin
                        reg_bytecnt <= '0;
                    end
                end
                if (timeout_hit) begin
                    reg_bytecnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_bus_responder.sv
// Bench for usb_bus_responder: table of single-access vectors, directed
// burst/wrap/reset-abort sequences, then randomized bus traffic checked
// against a transaction-level model of address, burst index and read data.
module tb_usb_bus_responder;

    localparam int RLAT   = 2;
    localparam int BC     = 7;
    localparam int K_WR   = 0;
    localparam int K_RD   = 1;
    localparam int K_BOTH = 2;

    logic          clk_usb;
    logic          reset_n;
    logic [7:0]    usb_addr;
    logic [7:0]    usb_din;
    logic [7:0]    usb_dout;
    logic          usb_isout;
    logic          usb_rdn;
    logic          usb_wrn;
    logic          usb_cen;
    logic [7:0]    reg_address;
    logic [BC-1:0] reg_bytecnt;
    logic [7:0]    reg_datao;
    logic [7:0]    reg_datai;
    logic          reg_read;
    logic          reg_write;
    logic          reg_addrvalid;
    logic          bus_error;

    usb_bus_responder #(
        .pADDR_WIDTH  (8),
        .pBYTECNT_SIZE(BC),
        .pREAD_LATENCY(RLAT),
        .pTIMEOUT     (255)
    ) dut (
        .clk_usb      (clk_usb),
        .reset_n      (reset_n),
        .usb_addr     (usb_addr),
        .usb_din      (usb_din),
        .usb_dout     (usb_dout),
        .usb_isout    (usb_isout),
        .usb_rdn      (usb_rdn),
        .usb_wrn      (usb_wrn),
        .usb_cen      (usb_cen),
        .reg_address  (reg_address),
        .reg_bytecnt  (reg_bytecnt),
        .reg_datao    (reg_datao),
        .reg_datai    (reg_datai),
        .reg_read     (reg_read),
        .reg_write    (reg_write),
        .reg_addrvalid(reg_addrvalid),
        .bus_error    (bus_error)
    );

    initial clk_usb = 1'b0;
    always #5 clk_usb = ~clk_usb;

    int total = 0;
    int bad   = 0;

    // strobe events observed on the register side
    typedef struct {
        logic [7:0]    addr;
        logic [7:0]    data;
        logic [BC-1:0] cnt;
        int            cyc;
    } ev_t;

    ev_t        wq[$];
    ev_t        rq[$];
    int         cyc = 0;
    int         dout_chg_cyc = 0;
    logic [7:0] prev_dout = 8'h00;

    // transaction model: last accessed address and next burst index
    logic [7:0] m_addr = 8'h00;
    int         m_cnt  = 0;

    typedef struct {
        int         kind;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_addr;
        logic [7:0] exp_data;
        int         exp_nwr;
        int         exp_nrd;
        logic [7:0] exp_dout;
        logic       exp_isout;
    } vec_t;

    vec_t vecs[8];

    // observe strobes and read-data changes once per cycle
    always @(negedge clk_usb) begin
        ev_t e;
        cyc = cyc + 1;
        if (reg_write) begin
            e.addr = reg_address; e.data = reg_datao; e.cnt = reg_bytecnt; e.cyc = cyc;
            wq.push_back(e);
        end
        if (reg_read) begin
            e.addr = reg_address; e.data = 8'h00; e.cnt = reg_bytecnt; e.cyc = cyc;
            rq.push_back(e);
        end
        if (usb_dout != prev_dout) dout_chg_cyc = cyc;
        prev_dout = usb_dout;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"},  32'(usb_dout), 0);
        check({tag, "_isout"}, 32'(usb_isout), 0);
        check({tag, "_addr"},  32'(reg_address), 0);
        check({tag, "_cnt"},   32'(reg_bytecnt), 0);
        check({tag, "_datao"}, 32'(reg_datao), 0);
        check({tag, "_read"},  32'(reg_read), 0);
        check({tag, "_write"}, 32'(reg_write), 0);
        check({tag, "_avld"},  32'(reg_addrvalid), 0);
        check({tag, "_berr"},  32'(bus_error), 0);
    endtask

    task automatic open_ce();
        usb_cen = 1'b0;
        repeat (2) @(negedge clk_usb);
    endtask

    task automatic close_ce();
        usb_cen = 1'b1;
        repeat (3) @(negedge clk_usb);
        check("ce_off_avld", 32'(reg_addrvalid), 0);
        check("ce_off_cnt",  32'(reg_bytecnt), 0);
        m_cnt = 0;
    endtask

    // one host bus cycle; returns pad-direction sample and the model's burst index
    task automatic bus_cycle(input int kind, input logic [7:0] a, input logic [7:0] d,
                             output logic isout_seen, output int exp_idx);
        int hold;
        wq.delete();
        rq.delete();
        exp_idx = (a == m_addr) ? m_cnt : 0;
        m_addr  = a;
        m_cnt   = (exp_idx + 1) % (1 << BC);
        usb_addr  = a;
        usb_din   = d;
        reg_datai = d;
        repeat (2) @(negedge clk_usb);
        if (kind == K_RD) begin
            hold = int'($urandom_range(RLAT + 7, RLAT + 4));
            usb_rdn = 1'b0;
            repeat (3) @(negedge clk_usb);
            isout_seen = usb_isout;
            repeat (hold - 3) @(negedge clk_usb);
            usb_rdn = 1'b1;
        end else begin
            hold = int'($urandom_range(5, 3));
            usb_wrn = 1'b0;
            if (kind == K_BOTH) usb_rdn = 1'b0;
            repeat (3) @(negedge clk_usb);
            isout_seen = usb_isout;
            repeat (hold - 2) @(negedge clk_usb);
            usb_wrn = 1'b1;
            usb_rdn = 1'b1;
        end
        repeat (5) @(negedge clk_usb);
    endtask

    // bus cycle checked against the transaction model
    task automatic access(input int kind, input logic [7:0] a, input logic [7:0] d);
        logic       isout_seen;
        int         idx;
        logic [7:0] old_dout;
        old_dout = usb_dout;
        bus_cycle(kind, a, d, isout_seen, idx);
        check("acc_nwrite", 32'(wq.size()), (kind != K_RD) ? 1 : 0);
        check("acc_nread",  32'(rq.size()), (kind == K_RD) ? 1 : 0);
        if (wq.size() > 0) begin
            check("acc_waddr", 32'(wq[0].addr), 32'(a));
            check("acc_wdata", 32'(wq[0].data), 32'(d));
            check("acc_wcnt",  32'(wq[0].cnt), 32'(idx));
        end
        if (rq.size() > 0) begin
            check("acc_raddr", 32'(rq[0].addr), 32'(a));
            check("acc_rcnt",  32'(rq[0].cnt), 32'(idx));
            if (d != old_dout) check("acc_rlat", 32'(dout_chg_cyc - rq[0].cyc), RLAT + 1);
        end
        check("acc_dout",  32'(usb_dout), (kind == K_RD) ? 32'(d) : 32'(old_dout));
        check("acc_isout", 32'(isout_seen), (kind == K_RD) ? 1 : 0);
        check("acc_avld",  32'(reg_addrvalid), 1);
    endtask

    initial begin
        logic isout_seen;
        int   idx;
        int   seen;
        int   n_acc;
        int   kind;

        vecs[0] = '{K_WR,   8'h04, 8'hA5, 8'h04, 8'hA5, 1, 0, 8'h00, 1'b0};
        vecs[1] = '{K_RD,   8'h04, 8'h3C, 8'h04, 8'h00, 0, 1, 8'h3C, 1'b1};
        vecs[2] = '{K_BOTH, 8'h01, 8'h48, 8'h01, 8'h48, 1, 0, 8'h3C, 1'b0};
        vecs[3] = '{K_RD,   8'hFF, 8'h00, 8'hFF, 8'h00, 0, 1, 8'h00, 1'b1};
        vecs[4] = '{K_WR,   8'hFF, 8'hFF, 8'hFF, 8'hFF, 1, 0, 8'h00, 1'b0};
        vecs[5] = '{K_RD,   8'h80, 8'hC3, 8'h80, 8'h00, 0, 1, 8'hC3, 1'b1};
        vecs[6] = '{K_WR,   8'h00, 8'h5A, 8'h00, 8'h5A, 1, 0, 8'hC3, 1'b0};
        vecs[7] = '{K_BOTH, 8'h7E, 8'h81, 8'h7E, 8'h81, 1, 0, 8'hC3, 1'b0};

        reset_n   = 1'b0;
        usb_cen   = 1'b1;
        usb_rdn   = 1'b1;
        usb_wrn   = 1'b1;
        usb_addr  = 8'h00;
        usb_din   = 8'h00;
        reg_datai = 8'h00;
        repeat (3) @(negedge clk_usb);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk_usb);

        // single accesses, each in its own chip-enable window
        for (int i = 0; i < 8; i++) begin
            open_ce();
            bus_cycle(vecs[i].kind, vecs[i].addr, vecs[i].data, isout_seen, idx);
            check("vec_nwrite", 32'(wq.size()), 32'(vecs[i].exp_nwr));
            check("vec_nread",  32'(rq.size()), 32'(vecs[i].exp_nrd));
            if (wq.size() > 0) begin
                check("vec_waddr", 32'(wq[0].addr), 32'(vecs[i].exp_addr));
                check("vec_wdata", 32'(wq[0].data), 32'(vecs[i].exp_data));
                check("vec_wcnt",  32'(wq[0].cnt), 0);
            end
            if (rq.size() > 0) begin
                check("vec_raddr", 32'(rq[0].addr), 32'(vecs[i].exp_addr));
                check("vec_rcnt",  32'(rq[0].cnt), 0);
            end
            check("vec_dout",  32'(usb_dout), 32'(vecs[i].exp_dout));
            check("vec_isout", 32'(isout_seen), 32'(vecs[i].exp_isout));
            close_ce();
        end

        // 20-read burst at one address, then a new address restarts the index
        open_ce();
        for (int i = 0; i < 20; i++) begin
            bus_cycle(K_RD, 8'h03, 8'(8'h40 + i), isout_seen, idx);
            check("burst_nread", 32'(rq.size()), 1);
            if (rq.size() > 0) check("burst_cnt", 32'(rq[0].cnt), 32'(i));
            check("burst_dout", 32'(usb_dout), 32'(8'h40 + i));
        end
        bus_cycle(K_RD, 8'h05, 8'h99, isout_seen, idx);
        if (rq.size() > 0) check("burst_newaddr_cnt", 32'(rq[0].cnt), 0);
        else check("burst_newaddr_nread", 32'(rq.size()), 1);
        close_ce();

        // index wraps at 2^BC
        open_ce();
        for (int i = 0; i < 130; i++) begin
            bus_cycle(K_WR, 8'h22, 8'(i), isout_seen, idx);
            if (wq.size() > 0) check("wrap_cnt", 32'(wq[0].cnt), 32'(i % 128));
            else check("wrap_nwrite", 32'(wq.size()), 1);
        end
        close_ce();

        // read latency with a changing data value
        open_ce();
        access(K_RD, 8'h07, 8'h11);
        access(K_RD, 8'h07, 8'hEE);
        access(K_WR, 8'h07, 8'h12);
        close_ce();

        // reset while waiting for read data aborts the read
        open_ce();
        access(K_RD, 8'h09, 8'h77);
        rq.delete();
        usb_addr  = 8'h09;
        reg_datai = 8'h99;
        repeat (2) @(negedge clk_usb);
        usb_rdn = 1'b0;
        seen = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk_usb);
            if (reg_read) begin
                seen = 1;
                break;
            end
        end
        check("rst_rdpulse", 32'(seen), 1);
        reset_n = 1'b0;
        @(negedge clk_usb);
        check_all_zero("rst_mid");
        usb_rdn = 1'b1;
        usb_cen = 1'b1;
        repeat (2) @(negedge clk_usb);
        reset_n = 1'b1;
        repeat (8) @(negedge clk_usb);
        check("rst_dout_held", 32'(usb_dout), 0);
        check("rst_nread", 32'(rq.size()), 1);
        m_addr = 8'h00;
        m_cnt  = 0;
        open_ce();
        bus_cycle(K_WR, 8'h10, 8'h5A, isout_seen, idx);
        check("rst_after_nwrite", 32'(wq.size()), 1);
        if (wq.size() > 0) begin
            check("rst_after_addr", 32'(wq[0].addr), 32'h10);
            check("rst_after_data", 32'(wq[0].data), 32'h5A);
            check("rst_after_cnt",  32'(wq[0].cnt), 0);
        end
        close_ce();

        // randomized traffic in chip-enable windows of varying length
        for (int w = 0; w < 40; w++) begin
            open_ce();
            n_acc = int'($urandom_range(6, 1));
            for (int k = 0; k < n_acc; k++) begin
                kind = int'($urandom_range(9, 0));
                kind = (kind < 4) ? K_WR : (kind < 8) ? K_RD : K_BOTH;
                if ($urandom_range(4, 0) == 0) access(kind, 8'($urandom), 8'($urandom));
                else access(kind, 8'($urandom_range(3, 0)), 8'($urandom));
            end
            close_ce();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
